// File: rtl/cp0_reg.sv
// CP0 register file: BadVAddr, Count, Compare, Status, Cause, EPC with MFC0/MTC0 ports.
// Define CP0_TIMER_EN to enable the Count/Compare timer; otherwise both read 0 and TI stays 0.
module cp0_reg (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cp0_we,
  input  logic [4:0]  cp0_waddr,
  input  logic [2:0]  cp0_wsel,
  input  logic [31:0] cp0_wdata,
  input  logic [4:0]  cp0_raddr,
  input  logic [2:0]  cp0_rsel,
  output logic [31:0] cp0_rdata,
  input  logic [4:0]  excepttype_i,
  input  logic [31:0] exc_pc_i,
  input  logic        is_in_delayslot_i,
  input  logic [31:0] badvaddr_i,
  input  logic [5:0]  int_i,
  output logic [31:0] cp0_status,
  output logic [31:0] cp0_cause,
  output logic [31:0] cp0_epc,
  output logic [31:0] cp0_badvaddr,
  output logic        timer_int
);
  localparam logic [4:0] EXC_INT  = 5'h01;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_OV   = 5'h0c;
  localparam logic [4:0] EXC_ERET = 5'h0e;

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;

  localparam logic [31:0] STATUS_RST  = 32'h0040_0000;
  localparam logic [31:0] STATUS_MASK = 32'h0000_FF03;

  logic [31:0] status_q, status_d, cause_q, cause_d;
  logic [31:0] epc_q, epc_d, badvaddr_q, badvaddr_d;
  logic [31:0] count_q, compare_q;
  logic        ti_d;
  logic        is_eret, is_exc, wr_en;
  logic [4:0]  exccode;
  logic        exccode_vld;

  assign is_eret = (excepttype_i == EXC_ERET);
  assign is_exc  = (excepttype_i != '0) && !is_eret;
  // Any exception or ERET in flight drops the MTC0 for every register.
  assign wr_en   = cp0_we && (excepttype_i == '0) && (cp0_wsel == 3'd0);

  always_comb begin
    exccode     = '0;
    exccode_vld = 1'b1;
    case (excepttype_i)
      EXC_INT:  exccode = 5'd0;
      EXC_ADEL: exccode = 5'd4;
      EXC_ADES: exccode = 5'd5;
      EXC_SYS:  exccode = 5'd8;
      EXC_BP:   exccode = 5'd9;
      EXC_RI:   exccode = 5'd10;
      EXC_OV:   exccode = 5'd12;
      default:  exccode_vld = 1'b0;
    endcase
  end

`ifdef CP0_TIMER_EN
  logic tick_q;

  always_comb begin
    ti_d = cause_q[30];
    if (wr_en && cp0_waddr == REG_COMPARE) ti_d = 1'b0;
    else if (compare_q != '0 && count_q == compare_q) ti_d = 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tick_q    <= 1'b0;
      count_q   <= '0;
      compare_q <= '0;
    end else begin
      if (wr_en && cp0_waddr == REG_COUNT) begin
        tick_q  <= 1'b0;
        count_q <= cp0_wdata;
      end else begin
        tick_q  <= ~tick_q;
        count_q <= count_q + {31'b0, tick_q};
      end
      if (wr_en && cp0_waddr == REG_COMPARE) compare_q <= cp0_wdata;
    end
  end
`else
  assign ti_d      = 1'b0;
  assign count_q   = '0;
  assign compare_q = '0;
`endif

  always_comb begin
    status_d   = status_q;
    cause_d    = cause_q;
    epc_d      = epc_q;
    badvaddr_d = badvaddr_q;
    cause_d[15:10] = {int_i[5] | cause_q[30], int_i[4:0]};
    cause_d[30]    = ti_d;
    if (is_exc) begin
      status_d[1] = 1'b1;
      if (!status_q[1]) begin
        cause_d[31] = is_in_delayslot_i;
        epc_d       = is_in_delayslot_i ? exc_pc_i - 32'd4 : exc_pc_i;
      end
      if (exccode_vld) cause_d[6:2] = exccode;
      if (excepttype_i == EXC_ADEL || excepttype_i == EXC_ADES) badvaddr_d = badvaddr_i;
    end else if (is_eret) begin
      status_d[1] = 1'b0;
    end else if (wr_en) begin
      case (cp0_waddr)
        REG_STATUS: status_d     = (cp0_wdata & STATUS_MASK) | STATUS_RST;
        REG_CAUSE:  cause_d[9:8] = cp0_wdata[9:8];
        REG_EPC:    epc_d        = cp0_wdata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      status_q   <= STATUS_RST;
      cause_q    <= '0;
      epc_q      <= '0;
      badvaddr_q <= '0;
    end else begin
      status_q   <= status_d;
      cause_q    <= cause_d;
      epc_q      <= epc_d;
      badvaddr_q <= badvaddr_d;
    end
  end

  always_comb begin
    cp0_rdata = '0;
    if (cp0_rsel == 3'd0) begin
      case (cp0_raddr)
        REG_BADVADDR: cp0_rdata = badvaddr_q;
        REG_COUNT:    cp0_rdata = count_q;
        REG_COMPARE:  cp0_rdata = compare_q;
        REG_STATUS:   cp0_rdata = status_q;
        REG_CAUSE:    cp0_rdata = cause_q;
        REG_EPC:      cp0_rdata = epc_q;
        default: ;
      endcase
    end
  end

  assign cp0_status   = status_q;
  assign cp0_cause    = cause_q;
  assign cp0_epc      = epc_q;
  assign cp0_badvaddr = badvaddr_q;
  assign timer_int    = cause_q[30];
endmodule

// File: tb/tb_cp0_reg.sv
// Self-checking bench for cp0_reg: directed vectors plus randomized traffic against a field-level model.
module tb_cp0_reg;
  localparam logic [4:0] EXC_INT  = 5'h01;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_OV   = 5'h0c;
  localparam logic [4:0] EXC_ERET = 5'h0e;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cp0_we;
  logic [4:0]  cp0_waddr;
  logic [2:0]  cp0_wsel;
  logic [31:0] cp0_wdata;
  logic [4:0]  cp0_raddr;
  logic [2:0]  cp0_rsel;
  logic [31:0] cp0_rdata;
  logic [4:0]  excepttype_i;
  logic [31:0] exc_pc_i;
  logic        is_in_delayslot_i;
  logic [31:0] badvaddr_i;
  logic [5:0]  int_i;
  logic [31:0] cp0_status, cp0_cause, cp0_epc, cp0_badvaddr;
  logic        timer_int;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  cp0_reg dut (
    .clk(clk), .resetn(resetn),
    .cp0_we(cp0_we), .cp0_waddr(cp0_waddr), .cp0_wsel(cp0_wsel), .cp0_wdata(cp0_wdata),
    .cp0_raddr(cp0_raddr), .cp0_rsel(cp0_rsel), .cp0_rdata(cp0_rdata),
    .excepttype_i(excepttype_i), .exc_pc_i(exc_pc_i), .is_in_delayslot_i(is_in_delayslot_i),
    .badvaddr_i(badvaddr_i), .int_i(int_i),
    .cp0_status(cp0_status), .cp0_cause(cp0_cause), .cp0_epc(cp0_epc),
    .cp0_badvaddr(cp0_badvaddr), .timer_int(timer_int)
  );

  always #5 clk = ~clk;

  // Reference model: architectural fields kept separately, packed only when compared.
  logic [7:0]  m_im;
  logic        m_exl, m_ie, m_bd, m_ti;
  logic [5:0]  m_iphw;
  logic [1:0]  m_ipsw;
  logic [4:0]  m_code;
  logic [31:0] m_epc, m_bva, m_count, m_compare;
  logic        m_tick;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_im = '0; m_exl = 0; m_ie = 0; m_bd = 0; m_ti = 0; m_iphw = '0; m_ipsw = '0;
    m_code = '0; m_epc = '0; m_bva = '0; m_count = '0; m_compare = '0; m_tick = 0;
  endfunction

  function automatic logic [31:0] exp_status();
    return 32'h0040_0000 | (32'(m_im) << 8) | (32'(m_exl) << 1) | 32'(m_ie);
  endfunction

  function automatic logic [31:0] exp_cause();
    return (32'(m_bd) << 31) | (32'(m_ti) << 30) | (32'(m_iphw) << 10) | (32'(m_ipsw) << 8)
           | (32'(m_code) << 2);
  endfunction

  function automatic logic [31:0] exp_read(input logic [4:0] a, input logic [2:0] s);
    if (s != 0) return 32'h0;
    case (a)
      5'd8:  return m_bva;
      5'd9:  return m_count;
      5'd11: return m_compare;
      5'd12: return exp_status();
      5'd13: return exp_cause();
      5'd14: return m_epc;
      default: return 32'h0;
    endcase
  endfunction

  function automatic int code_of(input logic [4:0] t);
    case (t)
      EXC_INT: return 0;  EXC_ADEL: return 4; EXC_ADES: return 5; EXC_SYS: return 8;
      EXC_BP:  return 9;  EXC_RI:   return 10; EXC_OV:  return 12;
      default: return -1;
    endcase
  endfunction

  // Apply one rising edge to the model using the inputs currently driven.
  function automatic void model_step();
    logic is_eret, is_exc, wr, ti_n;
    logic [5:0] iphw_n;
    is_eret = (excepttype_i == EXC_ERET);
    is_exc  = (excepttype_i != 0) && !is_eret;
    wr      = cp0_we && (excepttype_i == 0) && (cp0_wsel == 0);
    ti_n    = m_ti;
    iphw_n  = {int_i[5] | m_ti, int_i[4:0]};
`ifdef CP0_TIMER_EN
    if (m_compare != 0 && m_count == m_compare) ti_n = 1;
    if (wr && cp0_waddr == 5'd11) ti_n = 0;
    if (wr && cp0_waddr == 5'd9) begin
      m_count = cp0_wdata; m_tick = 0;
    end else begin
      if (m_tick) m_count = m_count + 1;
      m_tick = !m_tick;
    end
    if (wr && cp0_waddr == 5'd11) m_compare = cp0_wdata;
`endif
    if (is_exc) begin
      if (!m_exl) begin
        m_bd  = is_in_delayslot_i;
        m_epc = is_in_delayslot_i ? exc_pc_i - 4 : exc_pc_i;
      end
      m_exl = 1;
      if (code_of(excepttype_i) >= 0) m_code = 5'(code_of(excepttype_i));
      if (excepttype_i == EXC_ADEL || excepttype_i == EXC_ADES) m_bva = badvaddr_i;
    end else if (is_eret) begin
      m_exl = 0;
    end else if (wr) begin
      if (cp0_waddr == 5'd12) begin
        m_im = cp0_wdata[15:8]; m_exl = cp0_wdata[1]; m_ie = cp0_wdata[0];
      end
      if (cp0_waddr == 5'd13) m_ipsw = cp0_wdata[9:8];
      if (cp0_waddr == 5'd14) m_epc = cp0_wdata;
    end
    m_ti   = ti_n;
    m_iphw = iphw_n;
  endfunction

  task automatic check_all();
    check("status", cp0_status, exp_status());
    check("cause", cp0_cause, exp_cause());
    check("epc", cp0_epc, m_epc);
    check("badvaddr", cp0_badvaddr, m_bva);
    check("timer_int", 32'(timer_int), 32'(m_ti));
    check("rdata", cp0_rdata, exp_read(cp0_raddr, cp0_rsel));
  endtask

  task automatic clear_inputs();
    cp0_we = 0; cp0_waddr = '0; cp0_wsel = '0; cp0_wdata = '0;
    excepttype_i = '0; exc_pc_i = '0; is_in_delayslot_i = 0; badvaddr_i = '0; int_i = '0;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    cp0_we = 1; cp0_waddr = a; cp0_wsel = 0; cp0_wdata = d;
    step();
    cp0_we = 0;
  endtask

  task automatic raise(input logic [4:0] t, input logic [31:0] pc, input logic ds,
                       input logic [31:0] bva);
    excepttype_i = t; exc_pc_i = pc; is_in_delayslot_i = ds; badvaddr_i = bva;
    step();
    excepttype_i = '0;
  endtask

  task automatic read_expect(input string tag, input logic [4:0] a, input logic [31:0] exp);
    cp0_raddr = a; cp0_rsel = 0;
    #1;
    check(tag, cp0_rdata, exp);
  endtask

  logic [4:0] exc_list [8];
  logic [4:0] addr_list [6];

  initial begin
    int unsigned wait_n;
    exc_list  = '{EXC_INT, EXC_ADEL, EXC_ADES, EXC_SYS, EXC_BP, EXC_RI, EXC_OV, EXC_ERET};
    addr_list = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14};
    clear_inputs();
    cp0_raddr = '0; cp0_rsel = '0;
    resetn = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_status", cp0_status, 32'h0040_0000);
    check("rst_cause", cp0_cause, 32'h0);
    check("rst_timer_int", 32'(timer_int), 32'h0);
    resetn = 1;
    check_all();

    read_expect("rd_status_rst", 5'd12, 32'h0040_0000);
    read_expect("rd_cause_rst", 5'd13, 32'h0000_0000);

    mtc0(5'd12, 32'hFFFF_FFFF);
    read_expect("rd_status_ff", 5'd12, 32'h0040_FF03);
    mtc0(5'd8, 32'hDEAD_BEEF);
    read_expect("badvaddr_ro", 5'd8, 32'h0);
    mtc0(5'd12, 32'h0000_0000);

    raise(EXC_ADEL, 32'hBFC0_1004, 1'b1, 32'h0000_0003);
    check("adel_epc", cp0_epc, 32'hBFC0_1000);
    check("adel_cause", cp0_cause, 32'h8000_0010);
    check("adel_bva", cp0_badvaddr, 32'h3);
    check("adel_exl", 32'(cp0_status[1]), 32'h1);

    raise(EXC_SYS, 32'h0000_0100, 1'b0, 32'h0);
    check("sys_epc_kept", cp0_epc, 32'hBFC0_1000);
    check("sys_code", 32'(cp0_cause[6:2]), 32'd8);
    raise(EXC_ERET, 32'h0, 1'b0, 32'h0);
    check("eret_exl", 32'(cp0_status[1]), 32'h0);

    cp0_we = 1; cp0_waddr = 5'd14; cp0_wdata = 32'h1234;
    raise(EXC_INT, 32'h0000_2000, 1'b0, 32'h0);
    cp0_we = 0;
    check("int_epc", cp0_epc, 32'h0000_2000);
    check("int_code", 32'(cp0_cause[6:2]), 32'd0);
    raise(EXC_ERET, 32'h0, 1'b0, 32'h0);

`ifdef CP0_TIMER_EN
    mtc0(5'd9, 32'h0);
    mtc0(5'd11, 32'h4);
    wait_n = 0;
    while (!timer_int && wait_n < 20) begin
      step();
      wait_n++;
    end
    check("timer_latency_ok", 32'(wait_n >= 8 && wait_n <= 9), 32'h1);
    repeat (4) step();
    check("timer_sticky", 32'(timer_int), 32'h1);
    mtc0(5'd11, 32'h100);
    check("timer_clear", 32'(timer_int), 32'h0);
`else
    mtc0(5'd9, 32'h55);
    mtc0(5'd11, 32'h4);
    read_expect("count_zero", 5'd9, 32'h0);
    read_expect("compare_zero", 5'd11, 32'h0);
    repeat (10) step();
    check("timer_off", 32'(timer_int), 32'h0);
`endif

    // Asynchronous reset between edges, with a write pending.
    cp0_we = 1; cp0_waddr = 5'd14; cp0_wdata = 32'hCAFE_0000;
    excepttype_i = EXC_ADES; badvaddr_i = 32'h77;
    #2 resetn = 0;
    #1;
    model_reset();
    check("mid_rst_status", cp0_status, 32'h0040_0000);
    check("mid_rst_epc", cp0_epc, 32'h0);
    check("mid_rst_bva", cp0_badvaddr, 32'h0);
    @(posedge clk);
    @(negedge clk);
    clear_inputs();
    resetn = 1;
    check_all();

    for (int i = 0; i < 600; i++) begin
      clear_inputs();
      if ($urandom_range(0, 3) == 0) int_i = 6'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        cp0_we    = 1;
        cp0_waddr = ($urandom_range(0, 7) == 0) ? 5'($urandom) : addr_list[$urandom_range(0, 5)];
        cp0_wsel  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
        cp0_wdata = $urandom;
        if (cp0_waddr == 5'd11 && $urandom_range(0, 1) == 0)
          cp0_wdata = m_count + 32'($urandom_range(0, 6));
        if (cp0_waddr == 5'd9 && $urandom_range(0, 1) == 0)
          cp0_wdata = 32'hFFFF_FFFE + 32'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 5) == 0) begin
        excepttype_i      = exc_list[$urandom_range(0, 7)];
        exc_pc_i          = $urandom;
        is_in_delayslot_i = 1'($urandom);
        badvaddr_i        = $urandom;
      end
      cp0_raddr = ($urandom_range(0, 5) == 0) ? 5'($urandom) : addr_list[$urandom_range(0, 5)];
      cp0_rsel  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
